// File: rtl/serial_tx_arbiter.sv
// Two-requester packet arbiter in front of a serial transmitter.
// Round-robin grant per packet, packet-locked ownership, stall-timeout forced release.
module serial_tx_arbiter #(
    parameter int BITS    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] a_data,
    input  logic            a_valid,
    input  logic            a_last,
    output logic            a_ready,
    input  logic [BITS-1:0] b_data,
    input  logic            b_valid,
    input  logic            b_last,
    output logic            b_ready,
    output logic [BITS-1:0] tx_data,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [1:0]      grant,
    output logic            timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state_reg;
    logic        last_b_reg;
    logic [15:0] cnt_reg;
    logic        timeout_reg;

    logic        own_last;
    logic        xfer;

    // Datapath follows the owner combinationally so a word can move on the first owned cycle.
    always_comb begin
        tx_data  = '0;
        tx_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        own_last = 1'b0;
        case (state_reg)
            OWN_A: begin
                tx_data  = a_data;
                tx_valid = a_valid;
                a_ready  = tx_ready;
                own_last = a_last;
            end
            OWN_B: begin
                tx_data  = b_data;
                tx_valid = b_valid;
                b_ready  = tx_ready;
                own_last = b_last;
            end
            default: ;
        endcase
    end

    assign xfer    = tx_valid & tx_ready;
    assign grant   = state_reg;
    assign timeout = timeout_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            last_b_reg  <= 1'b1;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (a_valid && (!b_valid || last_b_reg))
                        state_reg <= OWN_A;
                    else if (b_valid)
                        state_reg <= OWN_B;
                end
                OWN_A, OWN_B: begin
                    if (xfer) begin
                        cnt_reg <= '0;
                        if (own_last) begin
                            state_reg  <= IDLE;
                            last_b_reg <= (state_reg == OWN_B);
                        end
                    end else if (!tx_valid) begin
                        // Only an absent requester counts as a stall; backpressure never does.
                        if (cnt_reg == TO_LAST) begin
                            state_reg   <= IDLE;
                            last_b_reg  <= (state_reg == OWN_B);
                            timeout_reg <= 1'b1;
                            cnt_reg     <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter: stimulus pushes expected transfers,
// a negedge monitor pops and compares every accepted word.
module tb_serial_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data, b_data, tx_data;
    logic       a_valid, a_last, a_ready;
    logic       b_valid, b_last, b_ready;
    logic       tx_valid, tx_ready, timeout;
    logic [1:0] grant;

    typedef struct {
        logic [1:0] g;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    serial_tx_arbiter #(.BITS(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .timeout(timeout)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [7:0] d, input logic l);
        exp_t e;
        e.g = g; e.d = d; e.l = l;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every handshake must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_xfer: got grant %0b data %0h expected no transfer", grant, tx_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("xfer_grant", 32'(grant), 32'(e.g));
                chk("xfer_data", 32'(tx_data), 32'(e.d));
                chk("xfer_last", 32'(grant[1] ? b_last : a_last), 32'(e.l));
                $display("[TB] xfer grant=%0b data=%02h last=%0b", grant, tx_data, grant[1] ? b_last : a_last);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [1:0] exp_g [9];
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0};

        rst_n = 1'b0;
        a_data = 8'h00; a_valid = 1'b0; a_last = 1'b0;
        b_data = 8'h21; b_valid = 1'b1; b_last = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        smp();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_b_ready", 32'(b_ready), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_timeout", 32'(timeout), 0);
        tick();
        rst_n = 1'b1;

        // Contention after reset: A first (3 words), one IDLE, then B.
        a_valid = 1'b1; a_data = 8'h11;
        push(2'b01, 8'h11, 1'b0); push(2'b01, 8'h12, 1'b0); push(2'b01, 8'h13, 1'b1);
        smp();
        chk("c_idle_grant", 32'(grant), 0);
        chk("c_idle_txv", 32'(tx_valid), 0);
        tick();
        smp();
        chk("c_grant_a", 32'(grant), 1);
        chk("c_b_ready", 32'(b_ready), 0);
        tick(); a_data = 8'h12;
        tick(); a_data = 8'h13; a_last = 1'b1;
        tick(); a_valid = 1'b0; a_last = 1'b0;
        push(2'b10, 8'h21, 1'b0); push(2'b10, 8'h22, 1'b1);
        smp();
        chk("c_gap_grant", 32'(grant), 0);
        tick();
        smp();
        chk("c_grant_b", 32'(grant), 2);
        tick(); b_data = 8'h22; b_last = 1'b1;
        tick(); b_valid = 1'b0; b_last = 1'b0;
        smp();
        chk("c_end_grant", 32'(grant), 0);

        // Backpressure: 1000 stalled cycles with a_valid high never time out.
        a_valid = 1'b1; a_data = 8'h5a; a_last = 1'b1; tx_ready = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            smp();
            if (tx_data !== 8'h5a || grant !== 2'b01 || timeout !== 1'b0 || tx_valid !== 1'b1)
                bad++;
            tick();
        end
        chk("bp_stable_bad_cycles", 32'(bad), 0);
        push(2'b01, 8'h5a, 1'b1);
        tx_ready = 1'b1;
        tick(); a_valid = 1'b0; a_last = 1'b0;
        smp();
        chk("bp_release_grant", 32'(grant), 0);

        // Timeout: B sends one word then goes silent.
        b_valid = 1'b1; b_data = 8'h31;
        push(2'b10, 8'h31, 1'b0);
        tick();
        tick(); b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("to_pre_pulse", 32'(timeout), 0);
            chk("to_pre_grant", 32'(grant), 2);
            tick();
        end
        a_valid = 1'b1; a_data = 8'h41; a_last = 1'b1;
        push(2'b01, 8'h41, 1'b1);
        smp();
        chk("to_pulse", 32'(timeout), 1);
        chk("to_grant_idle", 32'(grant), 0);
        tick();
        smp();
        chk("to_pulse_end", 32'(timeout), 0);
        chk("to_a_wins", 32'(grant), 1);
        tick(); a_valid = 1'b0; a_last = 1'b0;

        // Race: a transfer when the counter sits at TIMEOUT-1 clears it.
        b_valid = 1'b1; b_data = 8'h51;
        push(2'b10, 8'h51, 1'b0);
        tick();
        tick(); b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("race_stall_to", 32'(timeout), 0);
            tick();
        end
        b_valid = 1'b1; b_data = 8'h52;
        push(2'b10, 8'h52, 1'b0);
        smp();
        chk("race_hit_to", 32'(timeout), 0);
        tick(); b_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("race_cleared_to", 32'(timeout), 0);
            chk("race_cleared_grant", 32'(grant), 2);
            tick();
        end
        b_valid = 1'b1; b_data = 8'h53; b_last = 1'b1;
        push(2'b10, 8'h53, 1'b1);
        smp();
        chk("race_late_to", 32'(timeout), 0);
        chk("race_late_grant", 32'(grant), 2);
        tick(); b_valid = 1'b0; b_last = 1'b0;
        smp();
        chk("race_end_grant", 32'(grant), 0);

        // Mid-packet reset during B's second word.
        b_valid = 1'b1; b_data = 8'h61;
        push(2'b10, 8'h61, 1'b0);
        tick();
        tick(); b_data = 8'h62;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_grant", 32'(grant), 0);
        chk("mr_tx_valid", 32'(tx_valid), 0);
        chk("mr_b_ready", 32'(b_ready), 0);
        chk("mr_tx_data", 32'(tx_data), 0);
        chk("mr_timeout", 32'(timeout), 0);
        a_valid = 1'b1; a_data = 8'h71; a_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h81; b_last = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-word packets alternate A/B with an IDLE between each.
        push(2'b01, 8'h71, 1'b1); push(2'b10, 8'h81, 1'b1);
        push(2'b01, 8'h72, 1'b1); push(2'b10, 8'h82, 1'b1);
        for (int i = 0; i < 9; i++) begin
            smp();
            chk($sformatf("alt_grant_%0d", i), 32'(grant), 32'(exp_g[i]));
            tick();
            if (i == 1) a_data = 8'h72;
            if (i == 3) b_data = 8'h82;
            if (i == 7) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
        end

        repeat (3) tick();
        chk("sb_empty", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx_arbiter.md
SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

Interface
REQ-001 Parameter BITS, default 8, SHALL set the width of the data word.
REQ-002 Parameter TIMEOUT, default 255, legal range 1..65535, SHALL set the stall-timeout length in clk cycles.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 a_data  input  BITS  SHALL carry requester A's data word.
REQ-006 a_valid  input  1  SHALL flag requester A's data as valid.
REQ-007 a_last  input  1  SHALL mark requester A's final word of a packet.
REQ-008 a_ready  output  1  SHALL accept requester A's data.
REQ-009 b_data  input  BITS  SHALL carry requester B's data word.
REQ-010 b_valid  input  1  SHALL flag requester B's data as valid.
REQ-011 b_last  input  1  SHALL mark requester B's final word of a packet.
REQ-012 b_ready  output  1  SHALL accept requester B's data.
REQ-013 tx_data  output  BITS  SHALL carry the word to the serial transmitter.
REQ-014 tx_valid  output  1  SHALL flag tx_data as valid.
REQ-015 tx_ready  input  1  SHALL indicate that the serial transmitter accepts a word.
REQ-016 grant  output  2  SHALL be the one-hot owner: bit0 = A, bit1 = B, 00 = idle.
REQ-017 timeout  output  1  SHALL be a registered one-cycle pulse on a forced release.

Function
REQ-018 Handshake: a transfer SHALL occur in any cycle where tx_valid and tx_ready are both high.
REQ-019 State machine: the block SHALL have the states IDLE, OWN_A and OWN_B; grant SHALL equal 00, 01 and 10 respectively.
REQ-020 In IDLE, tx_valid, a_ready and b_ready SHALL be 0, and tx_data SHALL be 0.
REQ-021 IDLE with only a_valid high SHALL go to OWN_A next cycle; with only b_valid high, to OWN_B; with neither, stay in IDLE.
REQ-022 IDLE with both valid high SHALL grant the requester not recorded in last_served (round-robin).
REQ-023 Arbitration latency: IDLE to first possible transfer SHALL be exactly one cycle; no transfer SHALL occur in the IDLE cycle.
REQ-024 In OWN_x: tx_data = x_data, tx_valid = x_valid, x_ready = tx_ready, all combinational; the other requester's ready SHALL be 0.
REQ-025 Packet lock: a grant SHALL persist until a transfer with x_last = 1; the next state is then IDLE and last_served := x.
REQ-026 Back-to-back packets from the same owner SHALL be separated by at least one IDLE cycle; no re-grant without arbitration.
REQ-027 Stall counter: 16 bits, cleared in IDLE and on every transfer.
REQ-028 Stall counter in OWN_x SHALL increment when x_valid = 0, and SHALL hold when x_valid = 1 (downstream backpressure never counts).
REQ-029 When the counter equals TIMEOUT-1 and is incrementing, the next state SHALL be IDLE, last_served := x and timeout SHALL pulse high for one cycle.
REQ-030 A transfer in the same cycle as the timeout condition SHALL take precedence: the transfer completes and the timeout is suppressed.
REQ-031 Forced release SHALL not drop a word: no transfer SHALL be in flight, because x_valid is 0.
REQ-032 Changes of x_data or x_last while x_valid is high and unaccepted are a requester protocol violation; the block need not detect them.

Reset
REQ-033 While rst_n = 0, the state SHALL be IDLE and grant, tx_valid, a_ready, b_ready, tx_data and timeout SHALL be 0.
REQ-034 While rst_n = 0, the counter SHALL be 0 and last_served SHALL be B, so A wins the first contention.
REQ-035 Reset asserted mid-packet SHALL abandon the packet immediately and asynchronously; no partial-packet resumption SHALL occur.
REQ-036 Arbitration SHALL start on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 Contention after reset: a_valid = b_valid = 1 -> grant = 01 after 1 cycle; A sends 3 words, last on word 3 -> IDLE 1 cycle -> grant = 10.
REQ-038 Backpressure: OWN_A, a_valid = 1, tx_ready = 0 for 1000 cycles -> no timeout; tx_data stable = a_data; grant held.
REQ-039 Timeout: TIMEOUT = 4, OWN_B, b_valid drops after 1 word -> timeout pulses 4 cycles later; grant = 00; A then wins if valid.
REQ-040 Race: TIMEOUT = 4, transfer on the exact cycle the counter hits 3 -> counter clears, timeout = 0, grant held.
REQ-041 Mid-packet reset: rst_n low during OWN_B word 2 -> all outputs 0 same cycle; after release, both valid -> grant = 01.
REQ-042 Single-word packets: A alternates 1-word packets (last = 1) with B continuously valid -> grants alternate 01, 10, 01 with an IDLE cycle between each.
